// File: rtl/sdac_pkg.sv
// Shared types and default parameter values for the serial DAC loader.
package sdac_pkg;

    // Load sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } sdac_state_t;

    localparam int DEF_N_CH       = 8;
    localparam int DEF_DW         = 12;
    localparam int DEF_CLK_HALF   = 1;
    localparam int DEF_LD_W       = 2;
    localparam int DEF_SETTLE_CYC = 30;

endpackage

// File: rtl/sdac_shift_chan.sv
// One DAC channel: captures its code into a shift register and presents one
// bit at a time on sri. With SDAC_CH_MASK_EN defined, a captured mask bit
// can silence the channel for the whole load; otherwise the mask is ignored.
module sdac_shift_chan
    import sdac_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int MSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          capture,
    input  logic          advance,
    input  logic          clear,
    input  logic [DW-1:0] code_in,
    input  logic          mask_in,
    output logic          sri,
    output logic          enabled
);

    logic [DW-1:0] shreg;
    logic          first_bit;
    logic          next_bit;
    logic          cap_en;

    assign first_bit = (MSB_FIRST != 0) ? code_in[DW-1] : code_in[0];
    assign next_bit  = (MSB_FIRST != 0) ? shreg[DW-1]   : shreg[0];

`ifdef SDAC_CH_MASK_EN
    logic mask_q;

    assign cap_en  = mask_in;
    assign enabled = mask_q;

    // Remember whether this channel takes part in the current load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q <= 1'b0;
        end else if (capture) begin
            mask_q <= mask_in;
        end
    end
`else
    logic unused_mask;

    assign unused_mask = mask_in;
    assign cap_en      = 1'b1;
    assign enabled     = 1'b1;
`endif

    // First bit goes out straight from the input code at capture; the rest
    // come from the shift register, which already holds the remaining bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
            sri   <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            sri   <= 1'b0;
        end else if (capture) begin
            shreg <= (MSB_FIRST != 0) ? (code_in << 1) : (code_in >> 1);
            sri   <= first_bit & cap_en;
        end else if (advance) begin
            shreg <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
            sri   <= next_bit & enabled;
        end
    end

endmodule

// File: rtl/serial_dac_loader.sv
// Serial DAC loader: shifts N_CH codes out in parallel on a shared SCLK,
// strobes LD low, then waits a settling time before pulsing done.
// Optional feature macro: SDAC_CH_MASK_EN (per-channel load enable).
module serial_dac_loader
    import sdac_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int DW         = DEF_DW,
    parameter int CLK_HALF   = DEF_CLK_HALF,
    parameter int LD_W       = DEF_LD_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int MSB_FIRST  = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_CH-1:0][DW-1:0]  code,
    input  logic [N_CH-1:0]          ch_mask,
    output logic                     SCLK,
    output logic [N_CH-1:0]          SRI,
    output logic [N_CH-1:0]          LD,
    output logic                     busy,
    output logic                     done
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [3:0]    HALF_LAST   = 4'(CLK_HALF - 1);
    localparam logic [3:0]    LD_LAST     = 4'(LD_W - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DW - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    sdac_state_t     state;
    logic [3:0]      half_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [3:0]      ld_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [N_CH-1:0] ch_en;

    logic accept;
    logic half_end;
    logic bit_advance;
    logic shift_exit;
    logic chan_clear;

    // The done cycle is already IDLE, but a held start must wait one more
    // cycle so back-to-back loads are spaced by a full idle cycle
    assign accept      = (state == ST_IDLE) && start && !abort && !done;
    assign half_end    = (state == ST_SHIFT) && (half_cnt == HALF_LAST);
    assign bit_advance = half_end && SCLK && (bit_cnt != BIT_LAST) && !abort;
    assign shift_exit  = half_end && SCLK && (bit_cnt == BIT_LAST);
    assign chan_clear  = abort || shift_exit;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        sdac_shift_chan #(
            .DW        (DW),
            .MSB_FIRST (MSB_FIRST)
        ) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .capture (accept),
            .advance (bit_advance),
            .clear   (chan_clear),
            .code_in (code[c]),
            .mask_in (ch_mask[c]),
            .sri     (SRI[c]),
            .enabled (ch_en[c])
        );
    end

    // Load sequencer: state, phase counters, SCLK, LD strobes, busy and done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            ld_cnt     <= '0;
            settle_cnt <= '0;
            SCLK       <= 1'b0;
            LD         <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        SCLK     <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        SCLK     <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end else if (half_end) begin
                        half_cnt <= '0;
                        if (SCLK) begin
                            SCLK <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state   <= ST_LOAD;
                                bit_cnt <= '0;
                                ld_cnt  <= '0;
                                LD      <= ~ch_en;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            SCLK <= 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 4'd1;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        LD     <= '1;
                        ld_cnt <= '0;
                    end else if (ld_cnt == LD_LAST) begin
                        state      <= ST_SETTLE;
                        LD         <= '1;
                        ld_cnt     <= '0;
                        settle_cnt <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + 4'd1;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    SCLK  <= 1'b0;
                    LD    <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_dac_loader.sv
// Bench for serial_dac_loader: three instances (defaults, LSB-first,
// CLK_HALF=3) driven from a vector table plus hand-written abort/reset runs.
module tb_serial_dac_loader;

    localparam int N_CH = 8;
    localparam int DW   = 12;

`ifdef SDAC_CH_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    abort;
    logic [2:0]              start;
    logic [N_CH-1:0][DW-1:0] code;
    logic [N_CH-1:0]         ch_mask;

    logic [2:0]              sclk_o;
    logic [2:0]              busy_o;
    logic [2:0]              done_o;
    logic [N_CH-1:0]         sri_o [3];
    logic [N_CH-1:0]         ld_o  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_dac_loader #(.MSB_FIRST(1)) dut0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .abort(abort),
        .code(code), .ch_mask(ch_mask), .SCLK(sclk_o[0]), .SRI(sri_o[0]),
        .LD(ld_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    serial_dac_loader #(.MSB_FIRST(0)) dut1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .abort(abort),
        .code(code), .ch_mask(ch_mask), .SCLK(sclk_o[1]), .SRI(sri_o[1]),
        .LD(ld_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    serial_dac_loader #(.CLK_HALF(3)) dut2 (
        .clk(clk), .rstn(rstn), .start(start[2]), .abort(abort),
        .code(code), .ch_mask(ch_mask), .SCLK(sclk_o[2]), .SRI(sri_o[2]),
        .LD(ld_o[2]), .busy(busy_o[2]), .done(done_o[2])
    );

    typedef struct {
        int            sel;
        logic [DW-1:0] c0;
        logic [DW-1:0] c3;
        logic [DW-1:0] w0;
        logic [DW-1:0] w3;
        int            doneAt;
        int            lastHi;
        int            hiCnt;
    } vec_t;

    vec_t vecs [4];

    logic [DW-1:0] words [N_CH];
    int ldLow [N_CH];
    int doneCyc, doneCnt, riseCnt, highCnt, lastHigh, firstLdLow, sriBad;
    int busyAt1, busyAtDone, sriAt1;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [N_CH-1:0][DW-1:0] mkCodes(input logic [DW-1:0] a,
                                                         input logic [DW-1:0] b);
        logic [N_CH-1:0][DW-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c] = (c == 3) ? b : a;
        return r;
    endfunction

    // Start one load on instance sel and record what appears on its outputs
    task automatic applyStimulus(input int sel, input logic [N_CH-1:0][DW-1:0] codes,
                                 input logic [N_CH-1:0] mask, input int budget);
        logic            prevSclk;
        logic [N_CH-1:0] prevSri;
        for (int c = 0; c < N_CH; c++) begin
            words[c] = '0;
            ldLow[c] = 0;
        end
        doneCyc = -1; doneCnt = 0; riseCnt = 0; highCnt = 0; lastHigh = -1;
        firstLdLow = -1; sriBad = 0; busyAt1 = -1; busyAtDone = -1; sriAt1 = -1;
        @(negedge clk);
        code       = codes;
        ch_mask    = mask;
        start[sel] = 1'b1;
        prevSclk   = 1'b0;
        prevSri    = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start[sel] = 1'b0;
            if (k == 2) begin
                code    = ~codes;
                ch_mask = ~mask;
            end
            if (k == 1) begin
                busyAt1 = int'(busy_o[sel]);
                sriAt1  = int'(sri_o[sel][0]);
            end
            if (sclk_o[sel]) begin
                highCnt++;
                lastHigh = k;
                if (!prevSclk) begin
                    riseCnt++;
                    for (int c = 0; c < N_CH; c++) words[c] = {words[c][DW-2:0], sri_o[sel][c]};
                end else if (sri_o[sel] != prevSri) begin
                    sriBad++;
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                if (!ld_o[sel][c]) begin
                    ldLow[c]++;
                    if (firstLdLow < 0) firstLdLow = k;
                end
            end
            if (done_o[sel]) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc    = k;
                    busyAtDone = int'(busy_o[sel]);
                end
            end
            prevSclk = sclk_o[sel];
            prevSri  = sri_o[sel];
        end
    endtask

    // Check that instance 0 shows its reset values right now
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sclk"}, int'(sclk_o[0]), 0);
        checkOutput({tag, "_sri"},  int'(sri_o[0]), 0);
        checkOutput({tag, "_ld"},   int'(ld_o[0]), 8'hFF);
        checkOutput({tag, "_busy"}, int'(busy_o[0]), 0);
        checkOutput({tag, "_done"}, int'(done_o[0]), 0);
    endtask

    // Main test sequence
    initial begin
        int q [$];
        int ldSeen;
        int doneSeen;
        int busySeen;

        vecs[0] = '{0, 12'hA5C, 12'h3C1, 12'hA5C, 12'h3C1, 57, 24, 12};
        vecs[1] = '{0, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 57, 24, 12};
        vecs[2] = '{1, 12'hA5C, 12'h001, 12'h3A5, 12'h800, 57, 24, 12};
        vecs[3] = '{2, 12'h5A3, 12'h001, 12'h5A3, 12'h001, 105, 72, 36};

        rstn    = 1'b0;
        abort   = 1'b0;
        start   = '0;
        code    = '0;
        ch_mask = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].sel, mkCodes(vecs[i].c0, vecs[i].c3), 8'h0F, vecs[i].doneAt + 3);
            checkOutput($sformatf("v%0d_w0", i), int'(words[0]), int'(vecs[i].w0));
            checkOutput($sformatf("v%0d_w3", i), int'(words[3]), int'(vecs[i].w3));
            checkOutput($sformatf("v%0d_w7", i), int'(words[7]), MASK_ON ? 0 : int'(vecs[i].w0));
            checkOutput($sformatf("v%0d_sri_first", i), sriAt1, int'(vecs[i].w0[DW-1]));
            checkOutput($sformatf("v%0d_rises", i), riseCnt, DW);
            checkOutput($sformatf("v%0d_high_cycles", i), highCnt, vecs[i].hiCnt);
            checkOutput($sformatf("v%0d_last_high", i), lastHigh, vecs[i].lastHi);
            checkOutput($sformatf("v%0d_sri_stable", i), sriBad, 0);
            checkOutput($sformatf("v%0d_ld_first", i), firstLdLow, vecs[i].lastHi + 1);
            checkOutput($sformatf("v%0d_ld0_width", i), ldLow[0], 2);
            checkOutput($sformatf("v%0d_ld7_width", i), ldLow[7], MASK_ON ? 0 : 2);
            checkOutput($sformatf("v%0d_done_cycle", i), doneCyc, vecs[i].doneAt);
            checkOutput($sformatf("v%0d_done_count", i), doneCnt, 1);
            checkOutput($sformatf("v%0d_busy_first", i), busyAt1, 1);
            checkOutput($sformatf("v%0d_busy_at_done", i), busyAtDone, 0);
        end

        $display("[TB] abort in SHIFT at cycle 10");
        @(negedge clk);
        code     = mkCodes(12'hA5C, 12'hA5C);
        ch_mask  = 8'hFF;
        start[0] = 1'b1;
        ldSeen   = 0;
        doneSeen = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (ld_o[0] != 8'hFF) ldSeen++;
            if (done_o[0]) doneSeen++;
            if (k == 10) abort = 1'b1;
            if (k == 11) begin
                checkResetOutputs("abort_shift");
                abort = 1'b0;
            end
        end
        checkOutput("abort_shift_ld_seen", ldSeen, 0);
        checkOutput("abort_shift_done_seen", doneSeen, 0);
        applyStimulus(0, mkCodes(12'hA5C, 12'hA5C), 8'hFF, 60);
        checkOutput("after_abort_done_cycle", doneCyc, 57);
        checkOutput("after_abort_w0", int'(words[0]), 12'hA5C);

        $display("[TB] abort and start together in IDLE");
        @(negedge clk);
        start[0] = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort    = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        for (int k = 1; k <= 60; k++) begin
            if (done_o[0]) doneSeen++;
            if (busy_o[0]) busySeen++;
            @(negedge clk);
        end
        checkOutput("abort_start_busy", busySeen, 0);
        checkOutput("abort_start_done", doneSeen, 0);

        $display("[TB] abort in SETTLE");
        @(negedge clk);
        start[0] = 1'b1;
        doneSeen = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (done_o[0]) doneSeen++;
            if (k == 40) abort = 1'b1;
            if (k == 41) begin
                checkOutput("abort_settle_busy", int'(busy_o[0]), 0);
                abort = 1'b0;
            end
        end
        checkOutput("abort_settle_done", doneSeen, 0);

        $display("[TB] start held high");
        @(negedge clk);
        start[0] = 1'b1;
        q.delete();
        for (int k = 1; k <= 180; k++) begin
            @(negedge clk);
            if (done_o[0]) q.push_back(k);
        end
        start[0] = 1'b0;
        checkOutput("held_done_count", q.size(), 3);
        if (q.size() == 3) begin
            checkOutput("held_done0", q[0], 57);
            checkOutput("held_done1", q[1], 115);
            checkOutput("held_done2", q[2], 173);
        end
        repeat (70) @(negedge clk);

        $display("[TB] reset during back-to-back loads");
        @(negedge clk);
        start[0] = 1'b1;
        q.delete();
        for (int k = 1; k <= 125; k++) begin
            @(negedge clk);
            if (done_o[0]) q.push_back(k);
            if (k == 60) begin
                rstn = 1'b0;
                #1;
                checkResetOutputs("mid_reset");
            end
            if (k == 62) rstn = 1'b1;
        end
        start[0] = 1'b0;
        checkOutput("reset_done_count", q.size(), 2);
        if (q.size() == 2) begin
            checkOutput("reset_done0", q[0], 57);
            checkOutput("reset_done1", q[1], 119);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
